// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader
//
// Streams a configuration bitstream into the single config chain of a
// WIDTH x HEIGHT kFPGA core. Words arrive over a valid/ready handshake and
// are serialised LSB-first, one bit per clock, with no bubbles between
// back-to-back words. The fabric is held in reset while the chain loads.
// It is released once the last bit is in place.
//
// Optional feature (define KFPGA_LOADER_VERIFY_EN):
//   A CRC-16-CCITT is accumulated over the loaded bits. The chain is then
//   rotated once through itself while a second CRC runs over the chain tail.
//   Matching CRCs finish in DONE. A mismatch finishes in FAIL.
//
// Ports:
//   clock               block clock, also the core config clock
//   reset               asynchronous, active-high
//   start               one-cycle pulse, begins a load (from IDLE/DONE/FAIL)
//   abort               terminates a load in progress
//   word_data           bitstream word, bit 0 is shifted first
//   word_valid          word_data valid
//   word_ready          loader accepts a word this cycle
//   busy                high in CLEAR/LOAD/VERIFY
//   done                success flag (held until the next start)
//   error               failure flag (held until the next start)
//   core_config_in      serial bit to the chain head
//   core_config_enable  chain shift enable
//   core_config_nreset  chain reset, active low
//   core_config_out     chain tail
//   core_nreset         fabric reset, active low
//   core_enable         fabric enable
module kfpga_config_loader #(
    parameter int WIDTH           = 1,
    parameter int HEIGHT          = 1,
    parameter int IOT_CONFIG_BITS = 8,
    parameter int LT_CONFIG_BITS  = 40,
    parameter int WORD_WIDTH      = 32,
    parameter int CLEAR_CYCLES    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  core_config_in,
    output logic                  core_config_enable,
    output logic                  core_config_nreset,
    input  logic                  core_config_out,
    output logic                  core_nreset,
    output logic                  core_enable
);

    localparam int CHAIN_LENGTH = 2 * (WIDTH + HEIGHT) * IOT_CONFIG_BITS
                                + WIDTH * HEIGHT * LT_CONFIG_BITS;
    localparam int NUM_WORDS    = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W        = $clog2(CHAIN_LENGTH + 1);
    localparam int CLR_W        = $clog2(CLEAR_CYCLES + 1);
    localparam int WW_CAP       = (WORD_WIDTH < CHAIN_LENGTH) ? WORD_WIDTH : CHAIN_LENGTH;

    localparam logic [CNT_W-1:0] CHAIN_C = CNT_W'(CHAIN_LENGTH);
    localparam logic [CNT_W-1:0] NWORD_C = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] WW_C    = CNT_W'(WW_CAP);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CLR_W-1:0] CLR_END = CLR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
`ifdef KFPGA_LOADER_VERIFY_EN
        S_VERIFY,
`endif
        S_DONE,
        S_FAIL
    } state_t;

    state_t             state, state_d;
    logic [CLR_W-1:0]   clear_cnt;
    logic [CNT_W-1:0]   words_accepted;
    logic [CNT_W-1:0]   bits_remaining;
    logic [CNT_W-1:0]   pending;
    logic [1:0]         done_cnt;
    logic               cfg_nreset_q;
    logic               last_bit;
    logic [WORD_WIDTH-1:0] shreg;

    logic               shift_en;
    logic               xfer;
    logic               load_last;
    logic               clear_last;
    logic               start_go;
    logic [CNT_W-1:0]   bits_after;

`ifdef KFPGA_LOADER_VERIFY_EN
    logic [15:0]        crc_load;
    logic [15:0]        crc_verify;
    logic [15:0]        crc_v_next;
    logic               rot_en;
    logic               rot_last;
    logic               crc_ok;

    // Serial CRC-16-CCITT, poly 0x1021, MSB-first feedback.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`else
    logic               unused_core_config_out;
    assign unused_core_config_out = core_config_out;
`endif

    // Datapath control decode
    always_comb begin
        shift_en   = (state == S_LOAD) && (pending != '0);
        // Refill one bit early so the next word follows without a bubble.
        word_ready = (state == S_LOAD) && (pending <= ONE_C) && (words_accepted < NWORD_C);
        xfer       = word_valid && word_ready;
        bits_after = shift_en ? (bits_remaining - ONE_C) : bits_remaining;
        load_last  = shift_en && (bits_remaining == ONE_C);
        clear_last = (clear_cnt == CLR_END);
        start_go   = (state_d == S_CLEAR) && (state != S_CLEAR);
`ifdef KFPGA_LOADER_VERIFY_EN
        rot_en     = (state == S_VERIFY);
        rot_last   = rot_en && (bits_remaining == ONE_C);
        crc_v_next = crc_step(crc_verify, core_config_out);
        // The final tail bit is folded in here, in the cycle it is rotated.
        crc_ok     = (crc_v_next == crc_load);
`endif
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (abort)           state_d = S_FAIL;
                else if (clear_last) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort) state_d = S_FAIL;
                else if (load_last) begin
`ifdef KFPGA_LOADER_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef KFPGA_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (abort)         state_d = S_FAIL;
                else if (rot_last) state_d = crc_ok ? S_DONE : S_FAIL;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy               = (state == S_CLEAR) || (state == S_LOAD);
        done               = (state == S_DONE);
        error              = (state == S_FAIL);
        core_config_enable = shift_en;
        // When the chain is stalled the serial line keeps its last bit.
        core_config_in     = shift_en ? shreg[0] : last_bit;
        core_config_nreset = cfg_nreset_q;
        core_nreset        = (state == S_DONE) && (done_cnt != 2'd0);
        core_enable        = (state == S_DONE) && (done_cnt == 2'd2);
`ifdef KFPGA_LOADER_VERIFY_EN
        busy = busy || rot_en;
        if (rot_en) begin
            core_config_enable = 1'b1;
            core_config_in     = core_config_out;
        end
`endif
    end

    // Control counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_cnt      <= '0;
            words_accepted <= '0;
            bits_remaining <= '0;
            pending        <= '0;
            done_cnt       <= 2'd0;
            cfg_nreset_q   <= 1'b0;
            last_bit       <= 1'b0;
        end else begin
            clear_cnt <= (state == S_CLEAR && !clear_last) ? clear_cnt + 1'b1 : '0;

            if (start_go)
                cfg_nreset_q <= 1'b0;
            else if (state == S_CLEAR && state_d == S_LOAD)
                cfg_nreset_q <= 1'b1;

            if (state == S_DONE && done_cnt != 2'd2) done_cnt <= done_cnt + 2'd1;
            else if (state != S_DONE)                done_cnt <= 2'd0;

            if (start_go) begin
                words_accepted <= '0;
                bits_remaining <= CHAIN_C;
                pending        <= '0;
            end else if (state == S_LOAD) begin
                bits_remaining <= bits_after;
                if (xfer) begin
                    words_accepted <= words_accepted + ONE_C;
                    pending        <= (bits_after > WW_C) ? WW_C : bits_after;
                end else if (shift_en) begin
                    pending <= pending - ONE_C;
                end
                if (shift_en) last_bit <= shreg[0];
`ifdef KFPGA_LOADER_VERIFY_EN
                // The same counter then times the rotate pass.
                if (load_last) bits_remaining <= CHAIN_C;
            end else if (rot_en) begin
                bits_remaining <= bits_remaining - ONE_C;
                last_bit       <= core_config_out;
`endif
            end
        end
    end

    // Shift register and CRC data
    always_ff @(posedge clock) begin
        if (xfer)          shreg <= word_data;
        else if (shift_en) shreg <= shreg >> 1;
`ifdef KFPGA_LOADER_VERIFY_EN
        if (start_go)      crc_load <= 16'hFFFF;
        else if (shift_en) crc_load <= crc_step(crc_load, shreg[0]);
        if (load_last)     crc_verify <= 16'hFFFF;
        else if (rot_en)   crc_verify <= crc_v_next;
`endif
    end

endmodule
